ttfir_param: RTL and testbench

- Parametrised successor of the team's fixed 4-tap pin-limited FIR.
- Generic tap count and widths. A load state machine takes a programmable output shift and N_TAPS coefficients over the sample bus.
- Sample path has valid strobes, one-cycle output latency, arithmetic right-shift scaling and saturation to BW_OUT.
- Sits between the shared input pins and the output byte, as the chip-level datapath of the FIR project.

---
 rtl/ttfir_pkg.sv | 29 ++
 rtl/fir_tap_sum.sv | 29 ++
 rtl/ttfir_param.sv | 114 +++++++++++
 tb/tb_ttfir_param.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ttfir_pkg.sv
// rtl/ttfir_pkg.sv - shared types, width helpers and saturation for the parametrised FIR
package ttfir_pkg;

    typedef enum logic [1:0] {
        LOAD_SHIFT = 2'd0,
        LOAD_COEF  = 2'd1,
        RUN        = 2'd2
    } ttfir_state_t;

    // Accumulator width that can hold the sum of n_taps full products without overflow
    function automatic int sum_width(input int n_taps, input int bw_in);
        return 2 * bw_in + $clog2(n_taps);
    endfunction

    function automatic int shift_width(input int bw_sum);
        return $clog2(bw_sum);
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int bw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_tap_sum.sv
// rtl/fir_tap_sum.sv - combinational multiply and adder tree over packed history/coefficients
module fir_tap_sum #(
    parameter int N_TAPS = 4,
    parameter int BW_IN  = 6,
    parameter int BW_SUM = 14
) (
    input  logic [N_TAPS*BW_IN-1:0] x_flat,
    input  logic [N_TAPS*BW_IN-1:0] h_flat,
    output logic signed [BW_SUM-1:0] sum
);

    logic signed [BW_IN-1:0]   xi;
    logic signed [BW_IN-1:0]   hi;
    logic signed [2*BW_IN-1:0] prod;

    always_comb begin
        sum  = '0;
        xi   = '0;
        hi   = '0;
        prod = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            xi   = x_flat[i*BW_IN +: BW_IN];
            hi   = h_flat[i*BW_IN +: BW_IN];
            prod = (2*BW_IN)'(xi) * (2*BW_IN)'(hi);
            sum  = sum + BW_SUM'(prod);
        end
    end

endmodule

// File: rtl/ttfir_param.sv
// rtl/ttfir_param.sv - parametrised FIR with serial coefficient load, scaling and saturation
module ttfir_param
    import ttfir_pkg::*;
#(
    parameter int N_TAPS = 4,
    parameter int BW_IN  = 6,
    parameter int BW_OUT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BW_IN-1:0]         in_data,
    input  logic                     in_valid,
    input  logic                     cfg_start,
    output logic                     loaded,
    output logic signed [BW_OUT-1:0] y_out,
    output logic                     y_valid
);

    localparam int BW_SUM  = sum_width(N_TAPS, BW_IN);
    localparam int SHIFT_W = shift_width(BW_SUM);
    localparam int IDX_W   = $clog2(N_TAPS);

    ttfir_state_t               state_q;
    ttfir_state_t               state_d;
    logic [SHIFT_W-1:0]         shift_q;
    logic [SHIFT_W-1:0]         shift_in;
    logic [IDX_W-1:0]           idx_q;
    logic [N_TAPS*BW_IN-1:0]    h_flat;
    logic [N_TAPS*BW_IN-1:0]    x_flat;
    logic                       pend_q;
    logic                       last_coef;
    logic signed [BW_SUM-1:0]   sum;
    logic signed [BW_SUM-1:0]   scaled;

    fir_tap_sum #(
        .N_TAPS(N_TAPS),
        .BW_IN (BW_IN),
        .BW_SUM(BW_SUM)
    ) u_tap_sum (
        .x_flat(x_flat),
        .h_flat(h_flat),
        .sum   (sum)
    );

    assign last_coef = (idx_q == IDX_W'(N_TAPS - 1));
    assign scaled    = sum >>> shift_q;
    assign loaded    = (state_q == RUN);

    always_comb begin
        shift_in = in_data[SHIFT_W-1:0];
        if (int'(in_data[SHIFT_W-1:0]) >= BW_SUM) begin
            shift_in = SHIFT_W'(BW_SUM - 1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (cfg_start) begin
            state_d = LOAD_SHIFT;
        end else if (in_valid) begin
            case (state_q)
                LOAD_SHIFT: state_d = LOAD_COEF;
                LOAD_COEF:  if (last_coef) state_d = RUN;
                RUN:        state_d = RUN;
                default:    state_d = LOAD_SHIFT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= LOAD_SHIFT;
        else       state_q <= state_d;
    end

    // pend_q marks a sample accepted last edge; its strobe survives a cfg_start
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
            h_flat  <= '0;
            x_flat  <= '0;
            pend_q  <= 1'b0;
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            pend_q  <= 1'b0;
            y_valid <= pend_q;
            if (pend_q) begin
                y_out <= BW_OUT'(sat_signed(64'(scaled), BW_OUT));
            end
            if (cfg_start) begin
                idx_q <= '0;
            end else if (in_valid) begin
                case (state_q)
                    LOAD_SHIFT: begin
                        shift_q <= shift_in;
                        idx_q   <= '0;
                    end
                    LOAD_COEF: begin
                        h_flat[idx_q*BW_IN +: BW_IN] <= in_data;
                        idx_q <= idx_q + 1'b1;
                        if (last_coef) x_flat <= '0;
                    end
                    RUN: begin
                        x_flat <= {x_flat[(N_TAPS-1)*BW_IN-1:0], in_data};
                        pend_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ttfir_param.sv
// tb/tb_ttfir_param.sv - randomized self-checking bench for ttfir_param against a behavioural model
module tb_ttfir_param;

    localparam int N_TAPS = 4;
    localparam int BW_IN  = 6;
    localparam int BW_OUT = 8;
    localparam int BW_SUM = 2 * BW_IN + 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [BW_IN-1:0]         in_data;
    logic                     in_valid;
    logic                     cfg_start;
    logic                     loaded;
    logic signed [BW_OUT-1:0] y_out;
    logic                     y_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: configuration phase, coefficient list, sample history, pending result
    int m_phase;
    int m_idx;
    int m_shift;
    int m_h[N_TAPS];
    int m_x[N_TAPS];
    int m_pend;
    int m_pend_y;
    int m_y;
    int m_yv;

    ttfir_param #(.N_TAPS(N_TAPS), .BW_IN(BW_IN), .BW_OUT(BW_OUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .cfg_start(cfg_start),
        .loaded   (loaded),
        .y_out    (y_out),
        .y_valid  (y_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int filter_out();
        int acc;
        int lim;
        acc = 0;
        for (int i = 0; i < N_TAPS; i++) acc += m_x[i] * m_h[i];
        acc = acc >>> m_shift;
        lim = 1 << (BW_OUT - 1);
        if (acc > lim - 1) acc = lim - 1;
        if (acc < -lim) acc = -lim;
        return acc;
    endfunction

    task automatic model_edge(input bit r, input bit c, input bit v, input int d);
        int s;
        m_yv = m_pend;
        if (m_pend != 0) m_y = m_pend_y;
        m_pend = 0;
        if (r) begin
            m_phase = 0; m_idx = 0; m_shift = 0; m_y = 0; m_yv = 0;
            for (int i = 0; i < N_TAPS; i++) begin m_h[i] = 0; m_x[i] = 0; end
        end else if (c) begin
            m_phase = 0;
            m_idx   = 0;
        end else if (v) begin
            if (m_phase == 0) begin
                s = d & ((1 << $clog2(BW_SUM)) - 1);
                m_shift = (s >= BW_SUM) ? BW_SUM - 1 : s;
                m_phase = 1;
                m_idx   = 0;
            end else if (m_phase == 1) begin
                m_h[m_idx] = d;
                if (m_idx == N_TAPS - 1) begin
                    m_phase = 2;
                    for (int i = 0; i < N_TAPS; i++) m_x[i] = 0;
                end else begin
                    m_idx++;
                end
            end else begin
                for (int i = N_TAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
                m_x[0]   = d;
                m_pend   = 1;
                m_pend_y = filter_out();
            end
        end
    endtask

    // Drive one cycle from a negedge, let the posedge happen, compare at the next negedge
    task automatic cyc(input bit r, input bit c, input bit v, input int d);
        reset     = r;
        cfg_start = c;
        in_valid  = v;
        in_data   = BW_IN'(d);
        model_edge(r, c, v, d);
        @(posedge clk);
        @(negedge clk);
        check_eq("y_valid", int'(y_valid), m_yv);
        check_eq("y_out", int'(y_out), m_y);
        check_eq("loaded", int'(loaded), (m_phase == 2) ? 1 : 0);
    endtask

    task automatic load_cfg(input int sh, input int h0, input int h1, input int h2, input int h3);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, sh);
        cyc(0, 0, 1, h0);
        cyc(0, 0, 1, h1);
        cyc(0, 0, 1, h2);
        cyc(0, 0, 1, h3);
    endtask

    initial begin
        reset = 1'b1; cfg_start = 1'b0; in_valid = 1'b0; in_data = '0;
        m_pend = 0;
        @(negedge clk);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 7);

        // impulse response
        load_cfg(0, 1, 2, 3, 4);
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        // saturation and arithmetic shift
        load_cfg(0, 31, 31, 31, 31);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 31);
        load_cfg(5, 31, 31, 31, 31);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 31);
        load_cfg(0, 31, 31, 31, 31);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, -32);
        load_cfg(5, 31, 31, 31, 31);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, -32);
        check_eq("neg_shift5", int'(y_out), -124);

        // shift field clamp: 15 exceeds BW_SUM-1
        load_cfg(15, 31, 31, 31, 31);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, -32);

        // gapped input
        load_cfg(0, 1, 2, 3, 4);
        cyc(0, 0, 1, 5); cyc(0, 0, 0, 9); cyc(0, 0, 1, -3); cyc(0, 0, 0, 9); cyc(0, 0, 0, 0);

        // reload mid-run with cfg_start and in_valid together
        cyc(0, 0, 1, 7);
        cyc(0, 1, 1, 11);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 2); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 3);
        cyc(0, 0, 0, 0);
        check_eq("reload_y", int'(y_out), 3);

        // reset mid-load after two coefficients
        cyc(0, 1, 0, 0); cyc(0, 0, 1, 2); cyc(0, 0, 1, 9); cyc(0, 0, 1, 8);
        cyc(1, 0, 1, 4);
        load_cfg(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 5); cyc(0, 0, 0, 0);

        // random traffic with occasional reloads and resets
        for (int n = 0; n < 3000; n++) begin
            bit r;
            bit c;
            bit v;
            int d;
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = int'($urandom_range(0, 63)) - 32;
            cyc(r, c, v, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
